// File: rtl/ctrl_pipe_pkg.sv
// rtl/ctrl_pipe_pkg.sv - shared constants for the control-word pipeline
package ctrl_pipe_pkg;

  localparam int DEF_W     = 4;
  localparam int DEF_DEPTH = 2;
  localparam int DEF_CNT_W = 16;

  // Control word layout: {RegWrite, MemWrite, ResultSrc[1:0]}
  localparam int REGWRITE_BIT  = 3;
  localparam int MEMWRITE_BIT  = 2;
  localparam int RESULTSRC_LSB = 0;

  localparam logic [DEF_W-1:0] BUBBLE = '0;

endpackage

// File: rtl/ctrl_pipe_slot.sv
// rtl/ctrl_pipe_slot.sv - one pipeline stage: valid bit, data, flush/hold/load, masking
module ctrl_pipe_slot
  import ctrl_pipe_pkg::*;
#(
  parameter int W = DEF_W
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         flush,
  input  logic         hold,
  input  logic         load_valid,
  input  logic [W-1:0] load_ctrl,
  output logic         valid,
  output logic [W-1:0] ctrl
);

  logic [W-1:0] data;

  // Flush beats hold beats load; an invalid slot always stores zero data
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (flush) begin
      valid <= 1'b0;
      data  <= '0;
    end else if (!hold) begin
      valid <= load_valid;
      data  <= load_valid ? load_ctrl : '0;
    end
  end

  // Mask so an empty slot can never drive RegWrite/MemWrite downstream
  always_comb begin
    ctrl = valid ? data : '0;
  end

endmodule

// File: rtl/ctrl_pipe_reg.sv
// rtl/ctrl_pipe_reg.sv - parametrised control pipeline with stall, flush and bubble counter
module ctrl_pipe_reg
  import ctrl_pipe_pkg::*;
#(
  parameter int W     = DEF_W,
  parameter int DEPTH = DEF_DEPTH,
  parameter int CNT_W = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [W-1:0]     in_ctrl,
  output logic             in_ready,
  input  logic [DEPTH-1:0] stall,
  input  logic [DEPTH-1:0] flush,
  output logic [DEPTH-1:0] stage_valid,
  output logic [DEPTH*W-1:0] stage_ctrl,
  output logic             out_valid,
  output logic [W-1:0]     out_ctrl,
  input  logic             cnt_clr,
  output logic [CNT_W-1:0] bubble_cnt
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic [DEPTH-1:0] hold;

  genvar k;
  generate
    for (k = 0; k < DEPTH; k++) begin : g_stage
      logic         ld_valid;
      logic [W-1:0] ld_ctrl;

      // A stage is frozen by a stall on itself or on any later stage
      assign hold[k] = |(stall >> k);

      if (k == 0) begin : g_head
        assign ld_valid = in_valid;
        assign ld_ctrl  = in_ctrl;
      end else begin : g_body
        // A held predecessor hands on a bubble rather than a duplicate
        assign ld_valid = stage_valid[k-1] & ~hold[k-1];
        assign ld_ctrl  = stage_ctrl[(k-1)*W +: W];
      end

      ctrl_pipe_slot #(.W(W)) u_slot (
        .clk        (clk),
        .reset      (reset),
        .flush      (flush[k]),
        .hold       (hold[k]),
        .load_valid (ld_valid),
        .load_ctrl  (ld_ctrl),
        .valid      (stage_valid[k]),
        .ctrl       (stage_ctrl[k*W +: W])
      );
    end
  endgenerate

  assign in_ready  = ~hold[0];
  assign out_valid = stage_valid[DEPTH-1];
  assign out_ctrl  = stage_ctrl[(DEPTH-1)*W +: W];

  // Count empty last-stage cycles, saturating; clear wins over increment
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      bubble_cnt <= '0;
    end else if (cnt_clr) begin
      bubble_cnt <= '0;
    end else if (!out_valid && bubble_cnt != CNT_MAX) begin
      bubble_cnt <= bubble_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_ctrl_pipe_reg.sv
// tb/tb_ctrl_pipe_reg.sv - self-checking bench for ctrl_pipe_reg
module tb_ctrl_pipe_reg;

  localparam int W = 4;
  localparam int DEPTH = 2;

  typedef struct packed {
    logic [DEPTH-1:0]        v;
    logic [DEPTH-1:0][W-1:0] d;
    logic [15:0]             c16;
    logic [2:0]              c3;
  } model_t;

  logic clk = 1'b0;
  logic reset = 1'b0;
  logic in_valid = 1'b0;
  logic [W-1:0] in_ctrl = '0;
  logic [DEPTH-1:0] stall = '0;
  logic [DEPTH-1:0] flush = '0;
  logic cnt_clr = 1'b0;

  logic in_ready, out_valid;
  logic [DEPTH-1:0] stage_valid;
  logic [DEPTH*W-1:0] stage_ctrl;
  logic [W-1:0] out_ctrl;
  logic [15:0] bubble_cnt;

  logic in_ready3, out_valid3;
  logic [DEPTH-1:0] stage_valid3;
  logic [DEPTH*W-1:0] stage_ctrl3;
  logic [W-1:0] out_ctrl3;
  logic [2:0] bubble_cnt3;

  int total = 0;
  int bad = 0;
  bit started = 1'b0;
  model_t m = '0;

  always #5 clk = ~clk;

  ctrl_pipe_reg u_dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ctrl(in_ctrl),
    .in_ready(in_ready), .stall(stall), .flush(flush),
    .stage_valid(stage_valid), .stage_ctrl(stage_ctrl),
    .out_valid(out_valid), .out_ctrl(out_ctrl),
    .cnt_clr(cnt_clr), .bubble_cnt(bubble_cnt)
  );

  ctrl_pipe_reg #(.W(W), .DEPTH(DEPTH), .CNT_W(3)) u_dut3 (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ctrl(in_ctrl),
    .in_ready(in_ready3), .stall(stall), .flush(flush),
    .stage_valid(stage_valid3), .stage_ctrl(stage_ctrl3),
    .out_valid(out_valid3), .out_ctrl(out_ctrl3),
    .cnt_clr(cnt_clr), .bubble_cnt(bubble_cnt3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference behaviour: a slot advances only if nothing at or after it is stalled
  function automatic model_t step_model(model_t s, logic iv, logic [W-1:0] ic,
                                        logic [DEPTH-1:0] st, logic [DEPTH-1:0] fl,
                                        logic clr);
    model_t n = s;
    logic [DEPTH-1:0] frozen;
    for (int k = 0; k < DEPTH; k++) begin
      frozen[k] = 1'b0;
      for (int j = k; j < DEPTH; j++) if (st[j]) frozen[k] = 1'b1;
    end
    if (clr) begin
      n.c16 = 0;
      n.c3 = 0;
    end else if (!s.v[DEPTH-1]) begin
      if (s.c16 < 16'hFFFF) n.c16 = s.c16 + 1;
      if (s.c3 < 3'd7) n.c3 = s.c3 + 1;
    end
    for (int k = 0; k < DEPTH; k++) begin
      if (fl[k]) begin
        n.v[k] = 1'b0; n.d[k] = '0;
      end else if (frozen[k]) begin
        n.v[k] = s.v[k]; n.d[k] = s.d[k];
      end else if (k == 0) begin
        n.v[0] = iv; n.d[0] = iv ? ic : '0;
      end else if (frozen[k-1] || !s.v[k-1]) begin
        n.v[k] = 1'b0; n.d[k] = '0;
      end else begin
        n.v[k] = 1'b1; n.d[k] = s.d[k-1];
      end
    end
    return n;
  endfunction

  function automatic logic [DEPTH*W-1:0] exp_ctrl(model_t s);
    logic [DEPTH*W-1:0] r = '0;
    for (int k = 0; k < DEPTH; k++) r[k*W +: W] = s.v[k] ? s.d[k] : '0;
    return r;
  endfunction

  // Advance the reference alongside the DUT
  always @(posedge clk or negedge reset) begin
    if (!reset) m <= '0;
    else m <= step_model(m, in_valid, in_ctrl, stall, flush, cnt_clr);
  end

  // Per-cycle comparison against the reference, away from the active edge
  always @(negedge clk) begin
    if (started) begin
      chk("stage_valid", 32'(stage_valid), 32'(m.v));
      chk("stage_ctrl", 32'(stage_ctrl), 32'(exp_ctrl(m)));
      chk("out_valid", 32'(out_valid), 32'(m.v[DEPTH-1]));
      chk("out_ctrl", 32'(out_ctrl), 32'(exp_ctrl(m) >> ((DEPTH-1)*W)));
      chk("in_ready", 32'(in_ready), 32'(stall == '0));
      chk("bubble_cnt16", 32'(bubble_cnt), 32'(m.c16));
      chk("bubble_cnt3", 32'(bubble_cnt3), 32'(m.c3));
      chk("stage_ctrl3", 32'(stage_ctrl3), 32'(exp_ctrl(m)));
    end
  end

  task automatic set_in(input logic v, input logic [W-1:0] c,
                        input logic [DEPTH-1:0] st, input logic [DEPTH-1:0] fl,
                        input logic clr);
    in_valid = v; in_ctrl = c; stall = st; flush = fl; cnt_clr = clr;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    tick();
    started = 1'b1;
    chk("rst_valid", 32'(stage_valid), 32'h0);
    chk("rst_cnt", 32'(bubble_cnt), 32'h0);
    reset = 1'b1;

    // Plain flow: A, 5, then an invalid F
    set_in(1, 4'hA, 2'b00, 2'b00, 0); tick();
    set_in(1, 4'h5, 2'b00, 2'b00, 0); tick();
    chk("flow_A", 32'(out_ctrl), 32'hA);
    set_in(0, 4'hF, 2'b00, 2'b00, 0); tick();
    chk("flow_5", 32'(out_ctrl), 32'h5);
    chk("flow_cnt", 32'(bubble_cnt), 32'd2);
    set_in(0, 4'h0, 2'b00, 2'b00, 0); tick();
    chk("flow_bubble", 32'({out_valid, out_ctrl}), 32'h0);
    tick();
    chk("flow_cnt_inc", 32'(bubble_cnt), 32'd3);

    // Stall on the last stage freezes both
    set_in(1, 4'hA, 2'b00, 2'b00, 0); tick();
    set_in(1, 4'h5, 2'b00, 2'b00, 0); tick();
    set_in(1, 4'h3, 2'b10, 2'b00, 0);
    #1 chk("stall_ready", 32'(in_ready), 32'h0);
    tick(); tick();
    chk("stall_s1", 32'(out_ctrl), 32'hA);
    chk("stall_s0", 32'(stage_ctrl[3:0]), 32'h5);
    set_in(1, 4'h3, 2'b00, 2'b00, 0); tick();
    chk("rel_5", 32'(out_ctrl), 32'h5);
    set_in(0, 4'h0, 2'b00, 2'b00, 0); tick();
    chk("rel_3", 32'(out_ctrl), 32'h3);

    // Stall only stage 0: bubble slips into stage 1
    set_in(1, 4'h5, 2'b00, 2'b00, 0); tick();
    set_in(0, 4'h0, 2'b01, 2'b00, 0); tick();
    chk("s0stall_out", 32'({out_valid, out_ctrl}), 32'h0);
    chk("s0stall_keep", 32'({stage_valid, stage_ctrl[3:0]}), 32'h15);

    // Flush and stall together on stage 1
    set_in(1, 4'hC, 2'b00, 2'b00, 0); tick();
    set_in(1, 4'h7, 2'b00, 2'b00, 0); tick();
    chk("pre_flush", 32'(out_ctrl), 32'hC);
    set_in(1, 4'h9, 2'b10, 2'b10, 0); tick();
    chk("flush_valid", 32'(stage_valid), 32'h1);
    chk("flush_out", 32'(out_ctrl), 32'h0);
    chk("flush_s0", 32'(stage_ctrl[3:0]), 32'h7);
    set_in(1, 4'h9, 2'b10, 2'b00, 0); tick();
    chk("flush_held", 32'({stage_valid, stage_ctrl}), 32'h107);

    // Asynchronous reset mid-stream
    set_in(1, 4'h1, 2'b00, 2'b00, 0); tick();
    chk("pre_rst", 32'(stage_valid), 32'h3);
    reset = 1'b0;
    #1;
    chk("arst_valid", 32'(stage_valid), 32'h0);
    chk("arst_out", 32'(out_ctrl), 32'h0);
    chk("arst_cnt", 32'({bubble_cnt3, bubble_cnt}), 32'h0);
    set_in(0, 4'h0, 2'b00, 2'b00, 0);
    tick();
    reset = 1'b1;

    // Idle pipe: small counter saturates; clear wins over a bubble
    for (int i = 0; i < 10; i++) tick();
    chk("sat3", 32'(bubble_cnt3), 32'd7);
    chk("cnt16_idle", 32'(bubble_cnt), 32'd10);
    set_in(0, 4'h0, 2'b00, 2'b00, 1); tick();
    chk("clr3", 32'(bubble_cnt3), 32'd0);
    chk("clr16", 32'(bubble_cnt), 32'd0);
    set_in(0, 4'h0, 2'b00, 2'b00, 0); tick();
    chk("after_clr", 32'(bubble_cnt), 32'd1);

    @(negedge clk);
    started = 1'b0;
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/ctrl_pipe_reg.md
# ctrl_pipe_reg

Parametrised control-signal pipeline register that replaces the fixed-width, single-stage, always-advance stage registers in the RISC-V core's control path. It carries a W-bit control word through DEPTH back-to-back stages with a per-stage valid bit, per-stage stall and flush, and bubble masking, so squashed or empty slots can never assert RegWrite/MemWrite downstream. It also counts bubbles leaving the last stage for performance monitoring. It sits between the decode/execute control logic and the memory/writeback consumers; the hazard unit drives stall/flush and reads the stage taps.

## Interface
- W, 4: control word width (for example {RegWrite, MemWrite, ResultSrc[1:0]}).
- DEPTH, 2: number of register stages, ≥1.
- CNT_W, 16: bubble counter width.
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- in_valid  in  1  upstream word valid.
- in_ctrl  in  W  upstream control word.
- in_ready  out  1  stage 0 accepts this cycle (= ~hold[0]).
- stall  in  DEPTH  stall[k] requests stage k hold.
- flush  in  DEPTH  flush[k] squashes stage k.
- stage_valid  out  DEPTH  valid bit of each stage.
- stage_ctrl  out  DEPTH*W  masked word of each stage; stage k at bits [k*W +: W].
- out_valid  out  1  = stage_valid[DEPTH-1].
- out_ctrl  out  W  masked last-stage word.
- cnt_clr  in  1  synchronous bubble counter clear.
- bubble_cnt  out  CNT_W  bubbles emitted at the last stage.

## Operation
- Effective hold chain (combinational):
  - hold[DEPTH-1] = stall[DEPTH-1].
  - hold[k] = stall[k] | hold[k+1] for k < DEPTH-1.
  - A stall therefore freezes its own stage and every older-index stage.
- Per-stage next state, in priority order:
  1. flush[k]: valid ← 0, data ← 0.
  2. hold[k]: valid and data retained.
  3. Otherwise load from the predecessor. Stage 0 loads in_valid and in_ctrl. Stage k>0 loads stage k-1; if stage k-1 holds, stage k loads a bubble (valid 0, data 0).
- Flush overrides hold on the same stage. A flushed held stage becomes a bubble and stays held.
- An input word is taken only when in_ready = 1 and flush[0] = 0. With in_ready = 0, the upstream stage keeps its word.
- Masking: stage_ctrl slice k = stage_valid[k] ? data[k] : 0. Outputs are never non-zero for an invalid slot.
- The stored data of an invalid slot is always 0, so masking is defence in depth.
- Bubble counter:
  - Each cycle, cnt_clr sets it to 0. Otherwise, if out_valid = 0, it increments, saturating at 2^CNT_W-1.
  - cnt_clr takes priority over increment.
  - A held invalid last stage counts every cycle.

## Timing
- Reset (async assert, any time): all stage_valid = 0, all data = 0, out_ctrl = 0, bubble_cnt = 0. in_ready reflects stall combinationally.
- Reset mid-operation discards all in-flight words; no partial state survives.
- Latency: a word accepted at edge t appears at out_ctrl after edge t+DEPTH-1 when no stall intervenes. Each stalled cycle adds one cycle.
- flush[k] asserted in cycle t: stage k reads invalid after edge t+1.
- stall/flush/in_* are sampled at the rising edge. in_ready, stage_ctrl and out_ctrl are glitch-free functions of registers and stall only.
- Counter update is visible one cycle after the bubble is observed.
- The first cycle after reset release counts as a bubble.

## Structure
- Shared package ctrl_pipe_pkg:
  - default W/DEPTH/CNT_W constants.
  - control-word field offsets (REGWRITE_BIT, MEMWRITE_BIT, RESULTSRC_LSB).
  - all-zero BUBBLE constant.
- Sub-module ctrl_pipe_slot: one stage (valid + W-bit data, flush/hold/load priority, masking). It is instantiated DEPTH times in a generate loop.
- Top level holds the hold chain, the input handshake and the saturating counter.

## Test plan
- W=4, DEPTH=2, no stall. Inputs (1,0xA), (1,0x5), (0,0xF) on consecutive cycles → out_ctrl 0xA, then 0x5, then 0x0 with out_valid 0, one cycle after each enters stage 1. bubble_cnt increments only on the last.
- stall[1]=1 for 2 cycles holding 0xA in stage 1 and 0x5 in stage 0 → in_ready=0, both stages frozen, input word 0x3 not taken. After release: out_ctrl 0x5, then 0x3.
- stall[0]=1 only, with stage 0 = 0x5 → stage 1 receives a bubble (out_valid 0, out_ctrl 0) next cycle, and stage 0 keeps 0x5.
- flush[1] and stall[1] together with stage 1 = 0xC → stage 1 becomes invalid with ctrl 0, and stays held; stage 0 still frozen.
- Async reset asserted mid-stream with both stages valid → immediately all stage_valid 0, out_ctrl 0, bubble_cnt 0.
- CNT_W=3 with an idle pipe for 10 cycles → bubble_cnt saturates at 7. cnt_clr together with a bubble → bubble_cnt 0 next cycle.
